// File: rtl/fbf_pkg.sv
// Shared definitions for the float-matrix operand loader: element width,
// loader state encoding and the element bit-offset helper.
package fbf_pkg;

  localparam int FLOAT_W = 32;

  typedef enum logic [1:0] {
    ST_LOAD_A  = 2'd0,
    ST_LOAD_B  = 2'd1,
    ST_PRESENT = 2'd2
  } fbf_state_e;

  // Bit offset of element k inside a flat operand bus.
  function automatic int elem_offset(input int k);
    return FLOAT_W * k;
  endfunction

endpackage

// File: rtl/fbf_operand_loader_if.sv
// Stream-in and adder-facing signals of the operand loader, bundled so the
// loader (slave) and its environment (master) see opposite directions.
interface fbf_operand_loader_if #(
  parameter int SIZE = 4
) ();
  logic [31:0]             in_data;
  logic                    in_valid;
  logic                    in_ready;
  logic [32*SIZE*SIZE-1:0] A;
  logic [32*SIZE*SIZE-1:0] B;
  logic                    A_stb;
  logic                    B_stb;
  logic                    result_ready;
  logic                    result_ack;
  logic                    busy;

  modport slave (
    input  in_data, in_valid, result_ready, result_ack,
    output in_ready, A, B, A_stb, B_stb, busy
  );

  modport master (
    output in_data, in_valid, result_ready, result_ack,
    input  in_ready, A, B, A_stb, B_stb, busy
  );
endinterface

// File: rtl/fbf_elem_reg.sv
// SIZE*SIZE x FLOAT_W register bank with one indexed write port, presented
// as a flat bus (element k at bits [FLOAT_W*k +: FLOAT_W]).
module fbf_elem_reg
  import fbf_pkg::*;
#(
  parameter int SIZE = 4,
  localparam int N  = SIZE * SIZE,
  localparam int CW = (N > 1) ? $clog2(N) : 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 we,
  input  logic [CW-1:0]        idx,
  input  logic [FLOAT_W-1:0]   wdata,
  output logic [FLOAT_W*N-1:0] data
);

  logic [FLOAT_W-1:0] mem_q [N];
  logic [FLOAT_W-1:0] mem_d [N];

  // Next-state of the bank: only the indexed element changes on a write.
  always_comb begin
    mem_d = mem_q;
    if (we) begin
      mem_d[idx] = wdata;
    end else begin
      mem_d = mem_q;
    end
  end

  // Bank storage; asynchronous reset discards any partial matrix.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < N; i++) begin
        mem_q[i] <= {FLOAT_W{1'b0}};
      end
    end else begin
      mem_q <= mem_d;
    end
  end

  for (genvar g = 0; g < N; g++) begin : g_flat
    assign data[elem_offset(g) +: FLOAT_W] = mem_q[g];
  end

endmodule

// File: rtl/fbf_operand_loader.sv
// Assembles two SIZE x SIZE float matrices from a word stream and presents
// them to the matrix adder until its result handshake completes.
module fbf_operand_loader
  import fbf_pkg::*;
#(
  parameter int SIZE = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 clr,
  fbf_operand_loader_if.slave  bus
);

  localparam int N  = SIZE * SIZE;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};

  fbf_state_e state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic stb_q, stb_d;
  logic busy_q, busy_d;
  logic in_ready_s, accept_s, we_a_s, we_b_s;
  logic [FLOAT_W*N-1:0] a_data_s, b_data_s;

  // Next-state, counter and write-enable decode.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    stb_d      = stb_q;
    we_a_s     = 1'b0;
    we_b_s     = 1'b0;
    in_ready_s = (state_q != ST_PRESENT);
    accept_s   = bus.in_valid && in_ready_s;

    if (clr) begin
      // Abort wins over a same-edge accept or result handshake.
      state_d = ST_LOAD_A;
      cnt_d   = CNT_ZERO;
      stb_d   = 1'b0;
    end else begin
      case (state_q)
        ST_LOAD_A: begin
          if (accept_s) begin
            we_a_s = 1'b1;
            if (cnt_q == CNT_LAST) begin
              cnt_d   = CNT_ZERO;
              state_d = ST_LOAD_B;
            end else begin
              cnt_d = cnt_q + CNT_ONE;
            end
          end else begin
            cnt_d = cnt_q;
          end
        end
        ST_LOAD_B: begin
          if (accept_s) begin
            we_b_s = 1'b1;
            if (cnt_q == CNT_LAST) begin
              cnt_d   = CNT_ZERO;
              state_d = ST_PRESENT;
              stb_d   = 1'b1;
            end else begin
              cnt_d = cnt_q + CNT_ONE;
            end
          end else begin
            cnt_d = cnt_q;
          end
        end
        ST_PRESENT: begin
          if (bus.result_ready && bus.result_ack) begin
            stb_d   = 1'b0;
            state_d = ST_LOAD_A;
          end else begin
            stb_d = stb_q;
          end
        end
        default: begin
          state_d = ST_LOAD_A;
          cnt_d   = CNT_ZERO;
          stb_d   = 1'b0;
        end
      endcase
    end

    busy_d = (state_d != ST_LOAD_A);
  end

  // Control state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_LOAD_A;
      cnt_q   <= CNT_ZERO;
      stb_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      stb_q   <= stb_d;
      busy_q  <= busy_d;
    end
  end

  fbf_elem_reg #(.SIZE(SIZE)) u_bank_a (
    .clk   (clk),
    .reset (reset),
    .we    (we_a_s),
    .idx   (cnt_q),
    .wdata (bus.in_data),
    .data  (a_data_s)
  );

  fbf_elem_reg #(.SIZE(SIZE)) u_bank_b (
    .clk   (clk),
    .reset (reset),
    .we    (we_b_s),
    .idx   (cnt_q),
    .wdata (bus.in_data),
    .data  (b_data_s)
  );

  assign bus.in_ready = in_ready_s;
  assign bus.A        = a_data_s;
  assign bus.B        = b_data_s;
  assign bus.A_stb    = stb_q;
  assign bus.B_stb    = stb_q;
  assign bus.busy     = busy_q;

endmodule
